// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out frame receiver: start bit, WIDTH data bits LSB first,
// even parity. Completed words are offered on a valid/ready output register.
module sipo_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             perr,
    output logic             overrun,
    input  logic             clr_ovr
);

    // state  | meaning
    // IDLE   | waiting for a start bit (din=1)
    // DATA   | sampling data bit cnt_q into the shift register
    // PARITY | sampling the parity bit; word completes at the end of this cycle
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ovr_q, ovr_d;
    logic             complete;
    logic             perr_new;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        dout_d   = dout_q;
        valid_d  = valid_q;
        perr_d   = perr_q;
        ovr_d    = ovr_q;
        complete = 1'b0;
        perr_new = 1'b0;

        case (state_q)
            IDLE: begin
                if (din) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                shift_d[cnt_q] = din;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = PARITY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PARITY: begin
                complete = 1'b1;
                perr_new = (^shift_q) ^ din;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (clr_ovr) begin
            ovr_d = 1'b0;
        end

        // A completing frame either replaces the held word (free or being
        // consumed this cycle) or is dropped; a drop beats a same-cycle clear.
        if (complete) begin
            if (!valid_q || dout_ready) begin
                dout_d  = shift_q;
                perr_d  = perr_new;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign perr       = perr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: directed frame vectors plus a
// randomized frame stream checked against a word-level reference model.
module tb_sipo_deserializer;

    localparam int W = 4;

    logic         clk;
    logic         rst_r;
    logic         din_r;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         rdy_r;
    logic         perr;
    logic         overrun;
    logic         clr_r;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] ref_dout;
    logic         ref_v;
    logic         ref_perr;
    logic         ref_ovr;

    typedef struct {
        bit           d;
        bit           done;
        logic [W-1:0] word;
        bit           pb;
    } cyc_t;

    sipo_deserializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst_r),
        .din        (din_r),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (rdy_r),
        .perr       (perr),
        .overrun    (overrun),
        .clr_ovr    (clr_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, advance the word-level model by the rules of
    // the output register, then move to 1 time unit after the next rising edge.
    task automatic tick(input bit d, input bit rdy, input bit clr,
                        input bit done, input logic [W-1:0] word, input bit pb);
        din_r = d;
        rdy_r = rdy;
        clr_r = clr;
        if (rst_r) begin
            if (clr) ref_ovr = 1'b0;
            if (done) begin
                if (!ref_v || rdy) begin
                    ref_dout = word;
                    ref_perr = (($countones(word) + int'(pb)) % 2) != 0;
                    ref_v    = 1'b1;
                end else begin
                    ref_ovr = 1'b1;
                end
            end else if (ref_v && rdy) begin
                ref_v = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [W-1:0] data, input bit pb,
                              input bit rdy, input bit clr_last);
        tick(1'b1, rdy, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < W; i++) tick(data[i], rdy, 1'b0, 1'b0, '0, 1'b0);
        tick(pb, rdy, clr_last, 1'b1, data, pb);
    endtask

    task automatic do_reset();
        rst_r    = 1'b0;
        din_r    = 1'b0;
        rdy_r    = 1'b0;
        clr_r    = 1'b0;
        ref_dout = '0;
        ref_v    = 1'b0;
        ref_perr = 1'b0;
        ref_ovr  = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        rst_r = 1'b1;
    endtask

    task automatic test_reset();
        rst_r = 1'b0;
        din_r = 1'b0;
        rdy_r = 1'b0;
        clr_r = 1'b0;
        #1;
        checks++;
        if ({dout, dout_valid, perr, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: dout=%h valid=%b perr=%b ovr=%b, required all 0",
                     dout, dout_valid, perr, overrun);
        end
        @(posedge clk);
        #1;
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        send_frame(4'hD, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dout !== 4'hD || dout_valid !== 1'b1 || perr !== 1'b0) begin
            errors++;
            $display("FAIL basic_frame: dout=%h valid=%b perr=%b, required D 1 0",
                     dout, dout_valid, perr);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (dout !== 4'hD || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_hold: dout=%h valid=%b, required D 1", dout, dout_valid);
        end
    endtask

    task automatic test_parity_error();
        do_reset();
        send_frame(4'hD, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dout !== 4'hD || dout_valid !== 1'b1 || perr !== 1'b1) begin
            errors++;
            $display("FAIL parity_error: dout=%h valid=%b perr=%b, required D 1 1",
                     dout, dout_valid, perr);
        end
    endtask

    task automatic test_handshake();
        // Word from test_parity_error is still held.
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (dout_valid !== 1'b0 || dout !== 4'hD) begin
            errors++;
            $display("FAIL handshake_consume: valid=%b dout=%h, required 0 D", dout_valid, dout);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (dout_valid !== 1'b0 || dout !== 4'hD || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ready_while_empty: valid=%b dout=%h ovr=%b, required 0 D 0",
                     dout_valid, dout, overrun);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(4'hD, 1'b1, 1'b1, 1'b0);
        checks++;
        if (dout !== 4'hD || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: dout=%h valid=%b, required D 1", dout, dout_valid);
        end
        send_frame(4'h2, 1'b1, 1'b1, 1'b0);
        checks++;
        if (dout !== 4'h2 || dout_valid !== 1'b1 || perr !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: dout=%h valid=%b perr=%b ovr=%b, required 2 1 0 0",
                     dout, dout_valid, perr, overrun);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        send_frame(4'hD, 1'b1, 1'b0, 1'b0);
        send_frame(4'h2, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dout !== 4'hD || dout_valid !== 1'b1 || overrun !== 1'b1 || perr !== 1'b0) begin
            errors++;
            $display("FAIL overrun_set: dout=%h valid=%b ovr=%b perr=%b, required D 1 1 0",
                     dout, dout_valid, overrun, perr);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        checks++;
        if (overrun !== 1'b0 || dout !== 4'hD || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_clear: ovr=%b dout=%h valid=%b, required 0 D 1",
                     overrun, dout, dout_valid);
        end
        // Clear asserted in the same cycle as a new drop: the drop must win.
        send_frame(4'h5, 1'b0, 1'b0, 1'b1);
        checks++;
        if (overrun !== 1'b1 || dout !== 4'hD) begin
            errors++;
            $display("FAIL overrun_priority: ovr=%b dout=%h, required 1 D", overrun, dout);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_frame(4'hB, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        din_r = 1'b1;
        rst_r = 1'b0;
        #1;
        checks++;
        if ({dout, dout_valid, perr, overrun} !== '0) begin
            errors++;
            $display("FAIL midframe_reset_async: dout=%h valid=%b perr=%b ovr=%b, required all 0",
                     dout, dout_valid, perr, overrun);
        end
        ref_dout = '0;
        ref_v    = 1'b0;
        ref_perr = 1'b0;
        ref_ovr  = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        rst_r = 1'b1;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checks++;
        if (dout_valid !== 1'b0 || dout !== '0) begin
            errors++;
            $display("FAIL midframe_no_partial: valid=%b dout=%h, required 0 0", dout_valid, dout);
        end
        send_frame(4'h6, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dout !== 4'h6 || dout_valid !== 1'b1 || perr !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_frame: dout=%h valid=%b perr=%b, required 6 1 0",
                     dout, dout_valid, perr);
        end
    endtask

    task automatic test_random();
        cyc_t q[$];
        cyc_t c;
        logic [W-1:0] data;
        bit pb;
        int gap;
        int bad = 0;
        do_reset();
        for (int f = 0; f < 250; f++) begin
            data = W'($urandom);
            pb   = 1'($urandom);
            gap  = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) q.push_back('{1'b0, 1'b0, '0, 1'b0});
            q.push_back('{1'b1, 1'b0, '0, 1'b0});
            for (int i = 0; i < W; i++) q.push_back('{data[i], 1'b0, '0, 1'b0});
            q.push_back('{pb, 1'b1, data, pb});
        end
        for (int i = 0; i < 4; i++) q.push_back('{1'b0, 1'b0, '0, 1'b0});
        while (q.size() > 0) begin
            c = q.pop_front();
            tick(c.d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0),
                 c.done, c.word, c.pb);
            checks++;
            if (dout_valid !== ref_v || dout !== ref_dout || perr !== ref_perr ||
                overrun !== ref_ovr) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_stream t=%0t: valid=%b dout=%h perr=%b ovr=%b, required %b %h %b %b",
                             $time, dout_valid, dout, perr, overrun,
                             ref_v, ref_dout, ref_perr, ref_ovr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity_error();
        test_handshake();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
